// File: rtl/ufu_pkg.sv
// Shared types and constants for the UART->FIFO->UART packet controller.
package ufu_pkg;

  localparam int LENW = 16;
  localparam bit HDR_MSB_FIRST = 1'b1;

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_RX_LH = 4'd1,
    ST_RX_LL = 4'd2,
    ST_RX_D  = 4'd3,
    ST_DRAIN = 4'd4,
    ST_TX_H  = 4'd5,
    ST_TX_L  = 4'd6,
    ST_TX_D  = 4'd7,
    ST_DONE  = 4'd8
  } state_t;

  function automatic logic [7:0] hdr_byte(input logic [LENW-1:0] len, input logic first);
    if (first == HDR_MSB_FIRST) return len[15:8];
    return len[7:0];
  endfunction

endpackage

// File: rtl/ufu_sync_fifo.sv
// Single-clock FIFO with AW+1 bit wrapping pointers and a synchronous flush.
module ufu_sync_fifo #(
  parameter int DW = 8,
  parameter int AW = 8
) (
  input  logic          clk_bps,
  input  logic          rst_n,
  input  logic          i_flush,
  input  logic          i_wr_en,
  input  logic [DW-1:0] i_din,
  input  logic          i_rd_en,
  output logic [DW-1:0] o_dout,
  output logic          o_empty,
  output logic          o_full,
  output logic [AW:0]   o_level
);

  logic [DW-1:0] r_mem [0:(1<<AW)-1];
  logic [AW:0]   r_wr_ptr;
  logic [AW:0]   r_rd_ptr;
  logic          w_wr;
  logic          w_rd;

  assign o_empty = (r_wr_ptr == r_rd_ptr);
  assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
  assign o_level = r_wr_ptr - r_rd_ptr;
  assign o_dout  = r_mem[r_rd_ptr[AW-1:0]];
  assign w_wr    = i_wr_en && !o_full;
  assign w_rd    = i_rd_en && !o_empty;

  always_ff @(posedge clk_bps or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else begin
      if (w_wr) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd) r_rd_ptr <= r_rd_ptr + 1'b1;
    end
  end

  // Storage is not reset; only the pointers define validity.
  always_ff @(posedge clk_bps) begin
    if (w_wr && !i_flush) r_mem[r_wr_ptr[AW-1:0]] <= i_din;
  end

endmodule

// File: rtl/ufu_pkt_ctrl.sv
// Length-prefixed packet receiver that buffers the payload and echoes it to uart_tx.
module ufu_pkt_ctrl
  import ufu_pkg::*;
#(
  parameter int DW      = 8,
  parameter int DEPTH   = 256,
  parameter int AW      = 8,
  parameter int TIMEOUT = 4095
) (
  input  logic          clk_bps,
  input  logic          rst_n,
  input  logic          i_start,
  input  logic          i_hdr_en,
  input  logic          i_inv_en,
  input  logic          i_rx_ok,
  input  logic [DW-1:0] i_rx_data,
  input  logic          i_tx_busy,
  input  logic          i_tx_ok,
  output logic          o_tx_start,
  output logic [DW-1:0] o_tx_data,
  output logic          o_busy,
  output logic          o_done,
  output logic          o_err_len,
  output logic          o_err_tmo,
  output logic [AW:0]   o_level
);

  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [LENW:0] DEPTH_W = (LENW + 1)'(DEPTH);

  state_t          r_state, w_state_nxt;
  logic [LENW-1:0] r_len, r_rem, w_len_nxt;
  logic [TW-1:0]   r_tmo;
  logic            r_hdr, r_inv, r_out, r_tx_start, r_err_len, r_err_tmo;
  logic [DW-1:0]   r_tx_data, w_tx_word, w_fifo_dout;
  logic            w_rx_st, w_can_tx, w_issue, w_accept, w_set_len, w_set_tmo;
  logic            w_fifo_wr, w_fifo_rd, w_flush, w_fifo_empty, w_fifo_full;

  assign w_len_nxt = {r_len[15:8], i_rx_data[7:0]};
  assign w_rx_st   = (r_state == ST_RX_LH) || (r_state == ST_RX_LL) ||
                     (r_state == ST_RX_D)  || (r_state == ST_DRAIN);
  assign w_can_tx  = !i_tx_busy && !r_out;

  always_ff @(posedge clk_bps or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    w_accept    = 1'b0;
    w_fifo_wr   = 1'b0;
    w_fifo_rd   = 1'b0;
    w_flush     = 1'b0;
    w_set_len   = 1'b0;
    w_set_tmo   = 1'b0;
    w_tx_word   = '0;
    case (r_state)
      ST_IDLE: if (i_start) begin
        w_accept    = 1'b1;
        w_state_nxt = ST_RX_LH;
      end
      ST_RX_LH: if (i_rx_ok) w_state_nxt = ST_RX_LL;
      ST_RX_LL: if (i_rx_ok) begin
        if (w_len_nxt == '0)                 w_state_nxt = r_hdr ? ST_TX_H : ST_DONE;
        else if ({1'b0, w_len_nxt} > DEPTH_W) begin
          w_set_len   = 1'b1;
          w_state_nxt = ST_DRAIN;
        end else                             w_state_nxt = ST_RX_D;
      end
      ST_RX_D: if (i_rx_ok) begin
        w_fifo_wr = 1'b1;
        if (r_rem == 16'd1) w_state_nxt = r_hdr ? ST_TX_H : ST_TX_D;
      end
      ST_DRAIN: if (i_rx_ok && r_rem == 16'd1) w_state_nxt = ST_DONE;
      ST_TX_H: begin
        w_tx_word = DW'(hdr_byte(r_len, 1'b1));
        w_issue   = w_can_tx;
        if (i_tx_ok && r_out) w_state_nxt = ST_TX_L;
      end
      ST_TX_L: begin
        w_tx_word = DW'(hdr_byte(r_len, 1'b0));
        w_issue   = w_can_tx;
        if (i_tx_ok && r_out) w_state_nxt = w_fifo_empty ? ST_DONE : ST_TX_D;
      end
      ST_TX_D: begin
        w_tx_word = r_inv ? ~w_fifo_dout : w_fifo_dout;
        w_issue   = w_can_tx && !w_fifo_empty;
        w_fifo_rd = w_issue;
        if (i_tx_ok && r_out && w_fifo_empty) w_state_nxt = ST_DONE;
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
    // Silence on the line overrides whatever the receive state wanted.
    if (w_rx_st && !i_rx_ok && r_tmo == TW'(TIMEOUT)) begin
      w_state_nxt = ST_DONE;
      w_flush     = 1'b1;
      w_set_tmo   = 1'b1;
      w_fifo_wr   = 1'b0;
    end
  end

  always_ff @(posedge clk_bps or negedge rst_n) begin
    if (!rst_n) begin
      r_len      <= '0;
      r_rem      <= '0;
      r_tmo      <= '0;
      r_hdr      <= 1'b0;
      r_inv      <= 1'b0;
      r_out      <= 1'b0;
      r_tx_start <= 1'b0;
      r_tx_data  <= '0;
      r_err_len  <= 1'b0;
      r_err_tmo  <= 1'b0;
    end else begin
      if (w_accept) begin
        r_hdr     <= i_hdr_en;
        r_inv     <= i_inv_en;
        r_err_len <= 1'b0;
        r_err_tmo <= 1'b0;
      end
      if (w_set_len) r_err_len <= 1'b1;
      if (w_set_tmo) r_err_tmo <= 1'b1;
      if (r_state == ST_RX_LH && i_rx_ok) r_len[15:8] <= i_rx_data[7:0];
      if (r_state == ST_RX_LL && i_rx_ok) begin
        r_len <= w_len_nxt;
        r_rem <= w_len_nxt;
      end else if ((r_state == ST_RX_D || r_state == ST_DRAIN) && i_rx_ok && r_rem != '0) begin
        r_rem <= r_rem - 1'b1;
      end
      if (!w_rx_st || i_rx_ok || w_state_nxt != r_state) r_tmo <= '0;
      else                                                r_tmo <= r_tmo + 1'b1;
      r_tx_start <= w_issue;
      if (w_issue) begin
        r_tx_data <= w_tx_word;
        r_out     <= 1'b1;
      end else if (i_tx_ok) begin
        r_out     <= 1'b0;
      end
    end
  end

  ufu_sync_fifo #(.DW(DW), .AW(AW)) u_fifo (
    .clk_bps (clk_bps),
    .rst_n   (rst_n),
    .i_flush (w_flush),
    .i_wr_en (w_fifo_wr && !w_fifo_full),
    .i_din   (i_rx_data),
    .i_rd_en (w_fifo_rd),
    .o_dout  (w_fifo_dout),
    .o_empty (w_fifo_empty),
    .o_full  (w_fifo_full),
    .o_level (o_level)
  );

  assign o_tx_start = r_tx_start;
  assign o_tx_data  = r_tx_data;
  assign o_busy     = (r_state != ST_IDLE);
  assign o_done     = (r_state == ST_DONE);
  assign o_err_len  = r_err_len;
  assign o_err_tmo  = r_err_tmo;

endmodule

// File: tb/tb_ufu_pkt_ctrl.sv
// Scoreboard bench for ufu_pkt_ctrl with a simple uart_tx responder model.
module tb_ufu_pkt_ctrl;
  localparam int DW = 8, DEPTH = 256, AW = 8, TIMEOUT = 4095;

  logic          clk_bps = 1'b0;
  logic          rst_n   = 1'b0;
  logic          i_start = 1'b0, i_hdr_en = 1'b0, i_inv_en = 1'b0;
  logic          i_rx_ok = 1'b0, i_tx_busy = 1'b0, i_tx_ok = 1'b0;
  logic [DW-1:0] i_rx_data = '0;
  logic          o_tx_start, o_busy, o_done, o_err_len, o_err_tmo;
  logic [DW-1:0] o_tx_data;
  logic [AW:0]   o_level;

  always #5 clk_bps = ~clk_bps;

  ufu_pkt_ctrl #(.DW(DW), .DEPTH(DEPTH), .AW(AW), .TIMEOUT(TIMEOUT)) dut (
    .clk_bps(clk_bps), .rst_n(rst_n), .i_start(i_start), .i_hdr_en(i_hdr_en),
    .i_inv_en(i_inv_en), .i_rx_ok(i_rx_ok), .i_rx_data(i_rx_data),
    .i_tx_busy(i_tx_busy), .i_tx_ok(i_tx_ok), .o_tx_start(o_tx_start),
    .o_tx_data(o_tx_data), .o_busy(o_busy), .o_done(o_done),
    .o_err_len(o_err_len), .o_err_tmo(o_err_tmo), .o_level(o_level)
  );

  int            n_chk = 0, n_err = 0;
  int            n_tx = 0, n_done = 0, max_lvl = 0, tx_cnt = 0;
  logic [DW-1:0] sb[$];
  logic [DW-1:0] tx_hold = '0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // uart_tx responder and scoreboard consumer
  always @(negedge clk_bps) begin
    if (!rst_n) begin
      i_tx_busy = 1'b0;
      i_tx_ok   = 1'b0;
      tx_cnt    = 0;
    end else begin
      i_tx_ok = 1'b0;
      if (tx_cnt > 0) begin
        tx_cnt--;
        if (tx_cnt == 0) begin
          i_tx_busy = 1'b0;
          i_tx_ok   = 1'b1;
          chk("tx_hold", o_tx_data, tx_hold);
        end
      end
      if (o_tx_start) begin
        n_tx++;
        tx_hold   = o_tx_data;
        i_tx_busy = 1'b1;
        tx_cnt    = 4;
        if (sb.size() == 0) chk("tx_unexp", o_tx_start, 1'b0);
        else                chk("tx_data", o_tx_data, sb.pop_front());
      end
    end
    if (o_done) n_done++;
    if (int'(o_level) > max_lvl) max_lvl = int'(o_level);
  end

  task automatic rx_word(input logic [DW-1:0] d);
    @(negedge clk_bps);
    i_rx_data = d;
    i_rx_ok   = 1'b1;
    @(negedge clk_bps);
    i_rx_ok   = 1'b0;
    repeat (2) @(negedge clk_bps);
  endtask

  // Flip hdr/inv after start so late changes would show up as wrong output.
  task automatic start_pkt(input logic hdr, input logic inv);
    @(negedge clk_bps);
    i_start  = 1'b1;
    i_hdr_en = hdr;
    i_inv_en = inv;
    @(negedge clk_bps);
    i_start  = 1'b0;
    i_hdr_en = ~hdr;
    i_inv_en = ~inv;
  endtask

  task automatic send_len(input logic [15:0] len);
    rx_word(len[15:8]);
    rx_word(len[7:0]);
  endtask

  task automatic wait_done(input int max_cyc, input int base);
    int k = 0;
    while (n_done == base && k < max_cyc) begin
      @(negedge clk_bps);
      k++;
    end
    chk("done_seen", n_done - base, 1);
    repeat (3) @(negedge clk_bps);
    chk("done_once", n_done - base, 1);
  endtask

  task automatic new_test(output int base);
    base    = n_done;
    n_tx    = 0;
    max_lvl = 0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    logic [15:0] len;
    repeat (3) @(negedge clk_bps);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_txs", o_tx_start, 0);
    chk("rst_txd", o_tx_data, 0);
    chk("rst_lvl", o_level, 0);
    chk("rst_elen", o_err_len, 0);
    chk("rst_etmo", o_err_tmo, 0);
    rst_n = 1'b1;
    @(negedge clk_bps);

    // header + plain payload
    new_test(base);
    start_pkt(1'b1, 1'b0);
    sb.push_back(8'h00); sb.push_back(8'h03);
    sb.push_back(8'hA5); sb.push_back(8'h5A); sb.push_back(8'hFF);
    send_len(16'h0003);
    rx_word(8'hA5); rx_word(8'h5A); rx_word(8'hFF);
    wait_done(300, base);
    chk("t1_ntx", n_tx, 5);
    chk("t1_sb", sb.size(), 0);
    chk("t1_lvl", o_level, 0);
    chk("t1_elen", o_err_len, 0);
    chk("t1_etmo", o_err_tmo, 0);
    chk("t1_busy", o_busy, 0);

    // stray rx_ok while idle
    rx_word(8'h77);
    chk("idle_busy", o_busy, 0);
    chk("idle_lvl", o_level, 0);

    // inverted payload, no header, start pulsed mid-packet
    new_test(base);
    start_pkt(1'b0, 1'b1);
    sb.push_back(8'hF0); sb.push_back(8'h0F);
    send_len(16'h0002);
    rx_word(8'h0F);
    @(negedge clk_bps); i_start = 1'b1;
    @(negedge clk_bps); i_start = 1'b0;
    rx_word(8'hF0);
    wait_done(300, base);
    chk("t2_ntx", n_tx, 2);
    chk("t2_sb", sb.size(), 0);
    chk("t2_elen", o_err_len, 0);
    chk("t2_etmo", o_err_tmo, 0);

    // oversize length is drained
    new_test(base);
    start_pkt(1'b1, 1'b0);
    send_len(16'h0101);
    for (int i = 0; i < 257; i++) rx_word(8'(i));
    wait_done(100, base);
    chk("t3_elen", o_err_len, 1);
    chk("t3_ntx", n_tx, 0);
    chk("t3_lvl", o_level, 0);
    chk("t3_maxlvl", max_lvl, 0);

    // inter-word timeout
    new_test(base);
    start_pkt(1'b1, 1'b0);
    send_len(16'h0004);
    rx_word(8'h01); rx_word(8'h02);
    chk("t4_lvl2", o_level, 2);
    wait_done(TIMEOUT + 200, base);
    chk("t4_etmo", o_err_tmo, 1);
    chk("t4_elen", o_err_len, 0);
    chk("t4_lvl", o_level, 0);
    chk("t4_ntx", n_tx, 0);

    // full-depth packet
    new_test(base);
    start_pkt(1'b0, 1'b0);
    len = 16'(DEPTH);
    send_len(len);
    for (int i = 0; i < DEPTH; i++) begin
      sb.push_back(8'(i));
      rx_word(8'(i));
    end
    wait_done(4000, base);
    chk("t5_maxlvl", max_lvl, DEPTH);
    chk("t5_ntx", n_tx, DEPTH);
    chk("t5_sb", sb.size(), 0);
    chk("t5_lvl", o_level, 0);
    chk("t5_etmo", o_err_tmo, 0);

    // reset in the middle of transmission, then a fresh packet
    new_test(base);
    start_pkt(1'b0, 1'b0);
    sb.push_back(8'h11); sb.push_back(8'h22); sb.push_back(8'h33); sb.push_back(8'h44);
    send_len(16'h0004);
    rx_word(8'h11); rx_word(8'h22); rx_word(8'h33); rx_word(8'h44);
    for (int k = 0; k < 200 && n_tx < 2; k++) @(negedge clk_bps);
    chk("t6_midtx", n_tx, 2);
    rst_n = 1'b0;
    @(negedge clk_bps);
    chk("t6_busy", o_busy, 0);
    chk("t6_done", o_done, 0);
    chk("t6_txs", o_tx_start, 0);
    chk("t6_txd", o_tx_data, 0);
    chk("t6_lvl", o_level, 0);
    chk("t6_elen", o_err_len, 0);
    chk("t6_etmo", o_err_tmo, 0);
    repeat (2) @(negedge clk_bps);
    sb.delete();
    rst_n = 1'b1;
    @(negedge clk_bps);
    new_test(base);
    start_pkt(1'b0, 1'b0);
    sb.push_back(8'h3C);
    send_len(16'h0001);
    rx_word(8'h3C);
    wait_done(300, base);
    chk("t6_ntx", n_tx, 1);
    chk("t6_sb", sb.size(), 0);
    chk("t6_lvl_end", o_level, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
